// File: rtl/mips_pkg.sv
// Shared types and constants for the pipelined-MIPS fetch stage.
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;

    localparam word_t NOP = 32'h0000_0000;

    // Sequential PC step; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/mips_ifid_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+4 and a valid flag.
module mips_ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] instr_next,
    input  logic [31:0] pcplus4_next,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    // A clear loads a bubble; it only takes effect when the register is enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr   <= NOP_INSTR;
            pcplus4 <= 32'h0000_0000;
            valid   <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                instr   <= NOP_INSTR;
                pcplus4 <= 32'h0000_0000;
                valid   <= 1'b0;
            end else begin
                instr   <= instr_next;
                pcplus4 <= pcplus4_next;
                valid   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// Fetch stage: PC register, variable-latency imem handshake, decode redirects and the IF/ID register.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        redirectD,
    input  logic [31:0] targetD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    fetch_state_t state, state_next;
    word_t        buf_instr, buf_pc4, saved_target;
    word_t        pc_next, pc_inc;
    word_t        ifid_instr_next, ifid_pc4_next;
    logic         pc_we, buf_we, target_we, ifid_clear;
    logic         take_redirect;

    assign pc_inc        = pc_plus4(pcF);
    assign take_redirect = redirectD && !stallD;
    // pcF is never touched while a dropped request is in flight, so it is also the DROP address.
    assign imem_req      = reset_n && (state != HOLD);
    assign imem_addr     = pcF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FETCH;
            pcF          <= RESET_PC;
            buf_instr    <= NOP_INSTR;
            buf_pc4      <= 32'h0000_0000;
            saved_target <= RESET_PC;
        end else begin
            state <= state_next;
            if (pc_we && !stallF)
                pcF <= pc_next;
            if (buf_we) begin
                buf_instr <= imem_rdata;
                buf_pc4   <= pc_inc;
            end
            if (target_we)
                saved_target <= targetD;
        end
    end

    always_comb begin
        state_next      = state;
        pc_we           = 1'b0;
        pc_next         = pc_inc;
        buf_we          = 1'b0;
        target_we       = 1'b0;
        ifid_clear      = 1'b1;
        ifid_instr_next = imem_rdata;
        ifid_pc4_next   = pc_inc;

        unique case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (take_redirect) begin
                        pc_we   = 1'b1;
                        pc_next = targetD;
                    end else if (stallD) begin
                        buf_we     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_clear = 1'b0;
                        pc_we      = 1'b1;
                    end
                end else if (take_redirect) begin
                    target_we  = 1'b1;
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (!stallD) begin
                    state_next = FETCH;
                    pc_we      = 1'b1;
                    if (redirectD) begin
                        pc_next = targetD;
                    end else begin
                        ifid_clear      = 1'b0;
                        ifid_instr_next = buf_instr;
                        ifid_pc4_next   = buf_pc4;
                    end
                end
            end
            DROP: begin
                // The latest redirect wins, even one arriving with the stale response.
                if (take_redirect)
                    target_we = 1'b1;
                if (imem_ready) begin
                    pc_we      = 1'b1;
                    pc_next    = take_redirect ? targetD : saved_target;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    mips_ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (!stallD),
        .clear        (ifid_clear),
        .instr_next   (ifid_instr_next),
        .pcplus4_next (ifid_pc4_next),
        .instr        (instrD),
        .pcplus4      (pcplus4D),
        .valid        (validD)
    );

    a_no_redirect_while_stalled: assert property (
        @(posedge clk) disable iff (!reset_n) !(redirectD && stallD));

    a_target_aligned: assert property (
        @(posedge clk) disable iff (!reset_n) redirectD |-> (targetD[1:0] == 2'b00));

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed self-checking bench for mips_fetch_stage with a behavioural instruction memory.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stallF, stallD, redirectD;
    logic [31:0] targetD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pcF, instrD, pcplus4D;
    logic        validD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Each memory word encodes its own address so a stale or wrong fetch is visible in instrD.
    assign imem_rdata = {8'hA0, imem_addr[23:0]};

    mips_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stallF     (stallF),
        .stallD     (stallD),
        .redirectD  (redirectD),
        .targetD    (targetD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pcF        (pcF),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sd, input logic sf, input logic rd,
                                 input logic [31:0] tgt, input logic rdy);
        stallD     = sd;
        stallF     = sf;
        redirectD  = rd;
        targetD    = tgt;
        imem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_pcF", pcF, 32'h0);
        checkOutput("rst_instrD", instrD, 32'h0);
        checkOutput("rst_pcplus4D", pcplus4D, 32'h0);
        checkOutput("rst_validD", {31'b0, validD}, 32'd0);
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);

        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("first_req", {31'b0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, 32'h0);

        $display("[TB] zero-wait streaming");
        tick();
        checkOutput("t1_instr0", instrD, 32'hA000_0000);
        checkOutput("t1_pc4_0", pcplus4D, 32'h4);
        checkOutput("t1_valid0", {31'b0, validD}, 32'd1);
        tick();
        checkOutput("t1_instr1", instrD, 32'hA000_0004);
        checkOutput("t1_pcF1", pcF, 32'h8);
        tick();
        checkOutput("t1_instr2", instrD, 32'hA000_0008);
        checkOutput("t1_pc4_2", pcplus4D, 32'hC);
        checkOutput("t1_pcF2", pcF, 32'hC);

        $display("[TB] delayed ready");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t2_bubble_valid", {31'b0, validD}, 32'd0);
            checkOutput("t2_addr_stable", imem_addr, 32'hC);
            checkOutput("t2_req_held", {31'b0, imem_req}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t2_instr", instrD, 32'hA000_000C);
        checkOutput("t2_valid", {31'b0, validD}, 32'd1);
        checkOutput("t2_pcF", pcF, 32'h10);

        $display("[TB] decode stall with response");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t3_req_hold", {31'b0, imem_req}, 32'd0);
        checkOutput("t3_instr_held", instrD, 32'hA000_000C);
        checkOutput("t3_pcF_held", pcF, 32'h10);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("t3_req_hold2", {31'b0, imem_req}, 32'd0);
        checkOutput("t3_instr_held2", instrD, 32'hA000_000C);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("t3_buf_instr", instrD, 32'hA000_0010);
        checkOutput("t3_buf_pc4", pcplus4D, 32'h14);
        checkOutput("t3_pcF_adv", pcF, 32'h14);
        checkOutput("t3_req_back", {31'b0, imem_req}, 32'd1);

        $display("[TB] redirect during pending request");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        tick();
        checkOutput("t4_drop_valid", {31'b0, validD}, 32'd0);
        checkOutput("t4_drop_addr", imem_addr, 32'h14);
        checkOutput("t4_drop_req", {31'b0, imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t4_discard_valid", {31'b0, validD}, 32'd0);
        checkOutput("t4_new_addr", imem_addr, 32'h100);
        tick();
        checkOutput("t4_target_instr", instrD, 32'hA000_0100);
        checkOutput("t4_pcF", pcF, 32'h104);

        $display("[TB] double redirect in DROP");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        tick();
        checkOutput("t5_old_addr", imem_addr, 32'h104);
        checkOutput("t5_bubble", {31'b0, validD}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t5_latest_pc", pcF, 32'h300);
        tick();
        checkOutput("t5_latest_instr", instrD, 32'hA000_0300);
        checkOutput("t5_pcF", pcF, 32'h304);

        $display("[TB] redirect from HOLD");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t5h_req", {31'b0, imem_req}, 32'd0);
        checkOutput("t5h_instr_held", instrD, 32'hA000_0300);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
        tick();
        checkOutput("t5h_pcF", pcF, 32'h500);
        checkOutput("t5h_bubble_valid", {31'b0, validD}, 32'd0);
        checkOutput("t5h_bubble_instr", instrD, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t5h_instr", instrD, 32'hA000_0500);
        checkOutput("t5h_pc4", pcplus4D, 32'h504);

        $display("[TB] PC wrap");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        checkOutput("wrap_pcF_top", pcF, 32'hFFFF_FFFC);
        checkOutput("wrap_addr_lsb", {30'b0, imem_addr[1:0]}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("wrap_instr", instrD, 32'hA0FF_FFFC);
        checkOutput("wrap_pc4", pcplus4D, 32'h0);
        checkOutput("wrap_pcF", pcF, 32'h0);
        tick();
        checkOutput("wrap_next_instr", instrD, 32'hA000_0000);
        checkOutput("wrap_next_pcF", pcF, 32'h4);

        $display("[TB] reset mid-request");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_pcF", pcF, 32'h0);
        checkOutput("t6_instr", instrD, 32'h0);
        checkOutput("t6_pc4", pcplus4D, 32'h0);
        checkOutput("t6_valid", {31'b0, validD}, 32'd0);
        checkOutput("t6_req", {31'b0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("t6_late_ready_pcF", pcF, 32'h0);
        checkOutput("t6_late_ready_valid", {31'b0, validD}, 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("t6_restart_req", {31'b0, imem_req}, 32'd1);
        checkOutput("t6_restart_addr", imem_addr, 32'h0);
        tick();
        checkOutput("t6_restart_instr", instrD, 32'hA000_0000);
        checkOutput("t6_restart_valid", {31'b0, validD}, 32'd1);
        checkOutput("t6_restart_pcF", pcF, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
